// File: rtl/obi_sbr_mem_pipelined.sv
// OBI subordinate scratch RAM with byte-enable writes, out-of-range error responses and a response FIFO.
// Latency: response visible 1 cycle after the accept edge; up to MAX_OUTSTANDING responses may queue.
// Backpressure: obi_rready_i low holds the FIFO head; a full FIFO drops obi_gnt_o, and grant returns the cycle after a pop.
//
// Ports:
//   clk_i, reset_i               : clock, synchronous active-high reset
//   obi_req_i / obi_gnt_o        : A-channel handshake
//   obi_addr_i, obi_we_i,
//   obi_be_i, obi_wdata_i        : A-channel payload (byte address, write enable, byte lanes, write data)
//   obi_rvalid_o / obi_rready_i  : R-channel handshake
//   obi_rdata_o, obi_err_o       : R-channel payload (read data or ERR_DATA, error flag)
//   outstanding_o                : response FIFO occupancy (debug)
module obi_sbr_mem_pipelined #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH       = 64,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_DATA        = 32'hBADCAB1E,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  output logic [CNT_W-1:0]        outstanding_o
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS;
  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IDX_W:0]        DEPTH_X  = (IDX_W + 1)'(MEM_DEPTH);
  // ERR_DATA is 32 bits; narrower buses truncate it, wider ones zero-extend.
  localparam logic [DATA_WIDTH-1:0] ERR_D    = DATA_WIDTH'(ERR_DATA);

  // Storage: not reset, so it can be preloaded externally or hierarchically.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Response FIFO: circular buffer plus an explicit occupancy counter.
  logic [DATA_WIDTH-1:0] r_fifo_dat [MAX_OUTSTANDING];
  logic                  r_fifo_err [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [IDX_W-1:0]      w_word_idx;
  logic [MEM_AW-1:0]     w_mem_idx;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_push_dat;
  logic                  w_push_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // A channel
  // ---------------------------------------------------------------------------
  // Grant depends only on reset and FIFO occupancy, so there is no
  // combinational path from obi_rready_i to obi_gnt_o.
  assign obi_gnt_o = !reset_i && (r_count < MAX_CNT);
  assign w_accept  = obi_req_i && obi_gnt_o;

  // Low address bits select a byte within the word and are ignored.
  assign w_word_idx = obi_addr_i[ADDR_WIDTH-1:OFFS];
  // One extra bit so that MEM_DEPTH == 2**IDX_W cannot wrap to zero.
  assign w_in_range = ({1'b0, w_word_idx} < DEPTH_X);
  assign w_mem_idx  = w_word_idx[MEM_AW-1:0];
  assign w_rd_word  = mem[w_mem_idx];

  // Response payload captured at the accept edge. A read returns the word as
  // it stands before that edge; a write returns zero data.
  always_comb begin
    w_push_dat = '0;
    w_push_err = 1'b0;
    if (!w_in_range) begin
      w_push_dat = ERR_D;
      w_push_err = 1'b1;
    end else if (!obi_we_i) begin
      w_push_dat = w_rd_word;
    end
  end

  // Byte-lane write. w_accept is low during reset, so reset cycles never
  // disturb the array.
  always_ff @(posedge clk_i) begin
    if (w_accept && w_in_range && obi_we_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (obi_be_i[k]) begin
          mem[w_mem_idx][k*8 +: 8] <= obi_wdata_i[k*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  assign w_push = w_accept;
  assign w_pop  = obi_rvalid_o && obi_rready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_dat[r_wr_ptr] <= w_push_dat;
      r_fifo_err[r_wr_ptr] <= w_push_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      // Push is only possible below MAX_CNT and pop only above zero, so the
      // counter cannot overflow or underflow.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // R channel
  // ---------------------------------------------------------------------------
  assign obi_rvalid_o  = (r_count != '0);
  // Outputs read as zero when nothing is pending (including after reset).
  assign obi_rdata_o   = obi_rvalid_o ? r_fifo_dat[r_rd_ptr] : '0;
  assign obi_err_o     = obi_rvalid_o ? r_fifo_err[r_rd_ptr] : 1'b0;
  assign outstanding_o = r_count;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    r_count <= MAX_CNT);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
    (r_count == MAX_CNT) |-> !w_push);

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    (r_count == '0) |-> !w_pop);

  a_head_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (obi_rvalid_o && !obi_rready_i) |=> (obi_rvalid_o && $stable(obi_rdata_o) && $stable(obi_err_o)));
`endif

endmodule

// File: tb/tb_obi_sbr_mem_pipelined.sv
// Testbench for obi_sbr_mem_pipelined: directed and random transactions,
// scoreboard of expected responses popped by an independent R-channel monitor.
module tb_obi_sbr_mem_pipelined;

  localparam int DEPTH = 64;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic        obi_rready_i;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic [1:0]  outstanding_o;

  obi_sbr_mem_pipelined dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .obi_req_i     (obi_req_i),
    .obi_gnt_o     (obi_gnt_o),
    .obi_addr_i    (obi_addr_i),
    .obi_we_i      (obi_we_i),
    .obi_be_i      (obi_be_i),
    .obi_wdata_i   (obi_wdata_i),
    .obi_rvalid_o  (obi_rvalid_o),
    .obi_rready_i  (obi_rready_i),
    .obi_rdata_o   (obi_rdata_o),
    .obi_err_o     (obi_err_o),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;      // cycle number of the accept edge
    bit          chk_lat;  // response must be visible right after the accept edge
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  int          rr_mode = 1;   // 0: rready low, 1: rready high, 2: random
  bit          head_seen = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // rready driver; changes land at posedge+2 so mode switches made at
  // posedge+1 take effect in the same cycle.
  initial begin
    obi_rready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      case (rr_mode)
        0:       obi_rready_i = 1'b0;
        1:       obi_rready_i = 1'b1;
        default: obi_rready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // R-channel monitor: the head must match the oldest expected response on
  // every cycle it is shown, and it retires when rready is high.
  always @(negedge clk_i) begin
    if (reset_i) begin
      sb.delete();
      head_seen = 0;
    end else if (obi_rvalid_o) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b with nothing outstanding", obi_rdata_o, obi_err_o);
      end else begin
        if (obi_rdata_o !== sb[0].rdata || obi_err_o !== sb[0].err) begin
          bad++;
          $display("FAIL rsp: got rdata=%h err=%b, expected rdata=%h err=%b (cycle %0d)",
                   obi_rdata_o, obi_err_o, sb[0].rdata, sb[0].err, cyc);
        end
        if (!head_seen && sb[0].chk_lat) begin
          total++;
          if (cyc != sb[0].acc) begin
            bad++;
            $display("FAIL latency: response first seen in cycle %0d, expected %0d", cyc, sb[0].acc);
          end
        end
        head_seen = 1;
        if (obi_rready_i) begin
          void'(sb.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  // Drive one request, wait for grant, push the model's expected response.
  // Starts and ends at posedge+1.
  task automatic issue(input logic [31:0] a, input bit we, input logic [3:0] be,
                       input logic [31:0] wd, input bit lat);
    int   waitc = 0;
    bit   ok    = 1;
    exp_t e;
    obi_req_i   = 1'b1;
    obi_addr_i  = a;
    obi_we_i    = we;
    obi_be_i    = be;
    obi_wdata_i = wd;
    forever begin
      @(negedge clk_i);
      if (obi_gnt_o) break;
      waitc++;
      if (waitc > 50) begin
        total++;
        bad++;
        $display("FAIL gnt_timeout: no grant for addr %h, expected grant within 50 cycles", a);
        ok = 0;
        break;
      end
    end
    if (ok) begin
      e.acc     = cyc + 1;
      e.chk_lat = lat;
      if (a[31:2] >= DEPTH) begin
        e.rdata = 32'hBADCAB1E;
        e.err   = 1'b1;
      end else begin
        e.err = 1'b0;
        if (we) begin
          for (int k = 0; k < 4; k++)
            if (be[k]) mdl[a[31:2]][k*8 +: 8] = wd[k*8 +: 8];
          e.rdata = 32'h0;
        end else begin
          e.rdata = mdl[a[31:2]];
        end
      end
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    obi_req_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_compare(input string nm);
    int diffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut.mem[i] !== mdl[i]) diffs++;
    chk(nm, 32'(diffs), 32'd0);
  endtask

  initial begin
    int t0;
    logic [31:0] a;

    reset_i     = 1'b1;
    obi_req_i   = 1'b1;
    obi_addr_i  = 32'h0;
    obi_we_i    = 1'b1;
    obi_be_i    = 4'hF;
    obi_wdata_i = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]     = $urandom;
      dut.mem[i] = mdl[i];
    end
    mdl[0] = 32'h5A5A_0001; dut.mem[0] = mdl[0];
    mdl[1] = 32'hDA7A5EAD;  dut.mem[1] = mdl[1];
    mdl[2] = 32'hFFFFFFFF;  dut.mem[2] = mdl[2];

    // Reset held with a write request active: nothing granted, nothing written.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("rst_gnt", 32'(obi_gnt_o), 32'd0);
      chk("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
      chk("rst_outstanding", 32'(outstanding_o), 32'd0);
      chk("rst_rdata", obi_rdata_o, 32'd0);
      chk("rst_err", 32'(obi_err_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    reset_i   = 1'b0;
    obi_req_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_gnt", 32'(obi_gnt_o), 32'd1);
    chk("rst_mem0", dut.mem[0], 32'h5A5A_0001);
    @(posedge clk_i);
    #1;

    // Single read with latency check.
    issue(32'h4, 1'b0, 4'hF, 32'h0, 1'b1);
    drain();

    // Partial write then read back.
    issue(32'h8, 1'b1, 4'b0101, 32'h1337C0DE, 1'b1);
    issue(32'h8, 1'b0, 4'h0, 32'h0, 1'b1);
    drain();
    chk("pwrite_mem2", dut.mem[2], 32'hFF37FFDE);

    // Out-of-range read and write, plus a be=0 in-range write.
    issue(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b1);
    issue(32'h100, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1);
    issue(32'h10, 1'b1, 4'h0, 32'hCAFEF00D, 1'b1);
    drain();
    mem_compare("oor_mem_unchanged");

    // Backpressure: FIFO fills, third request waits for one pop.
    rr_mode = 0;
    issue(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    issue(32'h4, 1'b0, 4'h0, 32'h0, 1'b0);
    fork
      issue(32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i);
          chk("bp_gnt_full", 32'(obi_gnt_o), 32'd0);
          chk("bp_outstanding", 32'(outstanding_o), 32'd2);
        end
        @(posedge clk_i);
        #1;
        rr_mode = 1;
        @(negedge clk_i);
        chk("bp_gnt_same_cycle", 32'(obi_gnt_o), 32'd0);
        @(negedge clk_i);
        chk("bp_gnt_after_pop", 32'(obi_gnt_o), 32'd1);
      end
    join
    drain();

    // Streaming: 8 back-to-back reads, one accept per cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      issue(32'(i * 4), 1'b0, 4'h0, 32'h0, 1'b1);
    chk("stream_cycles", 32'(cyc - t0), 32'd8);
    drain();

    // Random traffic with random rready.
    rr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = $urandom;
      else
        a = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
      issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b0);
    end
    rr_mode = 1;
    drain();
    mem_compare("random_mem");

    // Reset mid-operation: queued responses discarded, no write during reset.
    rr_mode = 0;
    issue(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    issue(32'h4, 1'b0, 4'h0, 32'h0, 1'b0);
    reset_i     = 1'b1;
    obi_req_i   = 1'b1;
    obi_addr_i  = 32'hC;
    obi_we_i    = 1'b1;
    obi_be_i    = 4'hF;
    obi_wdata_i = ~mdl[3];
    @(negedge clk_i);
    chk("midrst_gnt", 32'(obi_gnt_o), 32'd0);
    @(negedge clk_i);
    chk("midrst_outstanding", 32'(outstanding_o), 32'd0);
    chk("midrst_rvalid", 32'(obi_rvalid_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_i   = 1'b0;
    obi_req_i = 1'b0;
    rr_mode   = 1;
    repeat (3) @(negedge clk_i);
    chk("midrst_no_rsp", 32'(obi_rvalid_o), 32'd0);
    chk("midrst_mem3", dut.mem[3], mdl[3]);
    @(posedge clk_i);
    #1;
    issue(32'hC, 1'b0, 4'h0, 32'h0, 1'b1);
    drain();
    mem_compare("final_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/obi_sbr_mem_pipelined.md
Name: obi_sbr_mem_pipelined

Overview:
- Parametrised OBI subordinate memory with byte-enable writes, out-of-range error responses and a response FIFO.
- Supports up to MAX_OUTSTANDING accepted-but-unretired transactions, so managers can pipeline requests back-to-back at one per cycle.
- Supports R-channel backpressure via obi_rready_i.
- Sits on the OBI interconnect as a generic scratch/data RAM target.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width in bits; multiple of 8, power of two.
- MEM_DEPTH, 64, number of DATA_WIDTH words of storage.
- MAX_OUTSTANDING, 2, response FIFO depth; minimum 1.
- ERR_DATA, 32'hBADCAB1E, rdata returned on error; truncated or zero-extended to DATA_WIDTH.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_i  in  1  synchronous active-high reset.
- obi_req_i  in  1  A-channel request.
- obi_gnt_o  out  1  A-channel grant.
- obi_addr_i  in  ADDR_WIDTH  byte address.
- obi_we_i  in  1  1 = write, 0 = read.
- obi_be_i  in  DATA_WIDTH/8  byte enables (writes only).
- obi_wdata_i  in  DATA_WIDTH  write data.
- obi_rvalid_o  out  1  R-channel response valid.
- obi_rready_i  in  1  R-channel ready from manager.
- obi_rdata_o  out  DATA_WIDTH  read data.
- obi_err_o  out  1  error flag for the current response.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy, for debug.

Behaviour:
- Clock and reset: one clock, clk_i. Reset reset_i is synchronous, active-high.
- Storage: array named mem, DATA_WIDTH x MEM_DEPTH. It is not cleared by reset and is preloadable by $readmemh / hierarchical access.
- Reset values: obi_gnt_o=0 while reset_i=1; obi_rvalid_o=0; obi_rdata_o=0; obi_err_o=0; outstanding_o=0. The FIFO is emptied.
- Reset mid-operation: all pending responses are discarded and no memory write occurs in the reset cycle.
- Grant: obi_gnt_o = !reset_i && (occupancy < MAX_OUTSTANDING). It does not depend on obi_req_i or obi_rready_i (no combinational R-to-A path).
- Acceptance: a transaction is accepted on a rising edge where obi_req_i && obi_gnt_o.
- Word index: obi_addr_i >> log2(DATA_WIDTH/8). Low address bits are ignored; no misalignment error.
- Out-of-range: word index >= MEM_DEPTH.
  - No memory access.
  - Response err=1, rdata=ERR_DATA for both reads and writes.
- In-range write: each byte lane k with obi_be_i[k]=1 is updated from obi_wdata_i on the accept edge. be=0 is legal: memory is unchanged and a normal response is generated. Response err=0, rdata=0.
- In-range read: rdata = mem[index] as it stands before the accept edge. Writes accepted in earlier cycles are visible; there is no same-cycle read/write conflict since one transaction is accepted per cycle. Response err=0.
- Response FIFO:
  - The response is pushed on the accept edge and is at the FIFO head at the earliest one cycle later (minimum latency 1 cycle, req to rvalid).
  - obi_rvalid_o = FIFO non-empty. obi_rdata_o and obi_err_o present the head entry and hold stable while rvalid=1 && rready=0.
  - Pop on a rising edge where obi_rvalid_o && obi_rready_i.
  - Responses are returned strictly in acceptance order.
- Simultaneous push and pop: occupancy unchanged.
- Full FIFO: grant is low. A pop in a full cycle raises grant on the next cycle, not the same cycle.
- Sustained throughput: with rready held at 1, back-to-back accepts at 1 per cycle are possible with MAX_OUTSTANDING >= 2. With MAX_OUTSTANDING=1, throughput is 1 transaction every 2 cycles.
- A-channel stability is the manager's responsibility; the subordinate samples only on accept edges.
- Occupancy counter: saturates by construction (never exceeds MAX_OUTSTANDING, never underflows). Assertions are required in the RTL under `ifndef SYNTHESIS.

Test Plan:
- Reset: hold reset_i=1 for 2 cycles with req=1 -> gnt=0, rvalid=0, outstanding_o=0, mem untouched. After release, gnt=1.
- Read: mem[1]=DA7A5EAD, req to addr 0x4, rready=1 -> accepted on the first edge, next cycle rvalid=1, rdata=DA7A5EAD, err=0.
- Partial write then read: write 0x1337C0DE to 0x8 with be=4'b0101 over old mem[2]=FFFFFFFF -> mem[2]=FF37FFDE. A following read of 0x8 returns FF37FFDE.
- Out-of-range: read 0xFFFF_FFFC and write 0x100 (MEM_DEPTH=64) -> each responds err=1, rdata=BADCAB1E, and no mem word changes.
- Backpressure: rready=0, issue 3 back-to-back reads (MAX_OUTSTANDING=2) -> first two granted, third sees gnt=0, outstanding_o=2, rdata stable. Set rready=1 -> responses drain in order, third is granted one cycle after the first pop.
- Pipelined streaming: rready=1, 8 consecutive reads of addresses 0..0x1C with req held high -> 8 accepts in 8 cycles, 8 in-order responses, each 1 cycle after its accept.
